// File: rtl/hold_dma.sv
// Bus-master block copy: borrows the data-memory port from the CPU via hold/holdACK.
// Optional interrupt output (irq/irq_ack) is built when HOLD_DMA_IRQ_EN is defined.
module hold_dma #(
    parameter int wide = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [31:0]     src,
    input  logic [31:0]     dst,
    input  logic [LENW-1:0] len,
    output logic            hold,
    input  logic            holdACK,
    output logic [31:0]     mem_a,
    output logic            mem_we,
    output logic [wide-1:0] mem_d,
    input  logic [wide-1:0] mem_q,
    output logic            busy,
    output logic            done
`ifdef HOLD_DMA_IRQ_EN
    ,
    output logic            irq,
    input  logic            irq_ack
`endif
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here
    // REQ   | hold raised, waiting for holdACK
    // RD    | reading source word (paused while grant is lost)
    // WR    | writing destination word (paused while grant is lost)
    // REL   | hold dropped, waiting for holdACK to fall
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

    state_t          state, state_n;
    logic [31:0]     sp, sp_n;
    logic [31:0]     dp, dp_n;
    logic [LENW-1:0] cnt, cnt_n;
    logic [LENW-1:0] cnt_dec;
    logic [wide-1:0] data_q, data_n;
    logic            abort_f, abort_n;
    logic            hold_n;
    logic            done_n;

    assign cnt_dec = cnt - LENW'(1);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sp      <= '0;
            dp      <= '0;
            cnt     <= '0;
            data_q  <= '0;
            abort_f <= 1'b0;
            hold    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            sp      <= sp_n;
            dp      <= dp_n;
            cnt     <= cnt_n;
            data_q  <= data_n;
            abort_f <= abort_n;
            hold    <= hold_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sp_n    = sp;
        dp_n    = dp;
        cnt_n   = cnt;
        data_n  = data_q;
        abort_n = (state == IDLE) ? 1'b0 : (abort_f | abort);
        done_n  = 1'b0;
        mem_a   = '0;
        mem_we  = 1'b0;
        mem_d   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    sp_n  = src & 32'hFFFF_FFFC;
                    dp_n  = dst & 32'hFFFF_FFFC;
                    cnt_n = len;
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (abort || abort_f) begin
                    state_n = REL;
                end else if (holdACK) begin
                    state_n = RD;
                end
            end
            RD: begin
                mem_a = sp;
                if (holdACK) begin
                    data_n  = mem_q;
                    state_n = WR;
                end
            end
            WR: begin
                mem_a  = dp;
                mem_d  = data_q;
                mem_we = holdACK;
                // a granted write always completes; abort only decides what follows it
                if (holdACK) begin
                    sp_n  = sp + 32'd4;
                    dp_n  = dp + 32'd4;
                    cnt_n = cnt_dec;
                    if ((cnt_dec == '0) || abort_f || abort) begin
                        state_n = REL;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            REL: begin
                if (!holdACK) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        hold_n = (state_n == REQ) || (state_n == RD) || (state_n == WR);
    end

`ifdef HOLD_DMA_IRQ_EN
    // set covers both the done pulse and the edge that raises it, so an ack
    // coinciding with done never clears the interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (done_n || done) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_hold_dma.sv
// Scoreboard bench for hold_dma: expected writes/completions are queued by the
// stimulus from a word-level copy model and popped by a negedge monitor.
module tb_hold_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        hold;
    logic        holdACK;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_d;
    logic [31:0] mem_q;
    logic        busy;
    logic        done;
`ifdef HOLD_DMA_IRQ_EN
    logic        irq;
    logic        irq_ack = 1'b0;
`endif

    hold_dma #(.wide(32), .LENW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
        .hold(hold), .holdACK(holdACK),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
        .busy(busy), .done(done)
`ifdef HOLD_DMA_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // memories: ram is what the DUT touches, mdl is the reference copy
    logic [31:0] ram [bit [29:0]];
    logic [31:0] mdl [bit [29:0]];
    int          ram_gen = 0;

    function automatic logic [31:0] init_word(input bit [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0000;
    endfunction
    function automatic logic [31:0] ram_rd(input bit [29:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction
    function automatic logic [31:0] mdl_rd(input bit [29:0] a);
        return mdl.exists(a) ? mdl[a] : init_word(a);
    endfunction

    always @(mem_a or ram_gen) mem_q = ram_rd(mem_a[31:2]);

    always @(posedge clk) begin
        if (!rst && mem_we) begin
            ram[mem_a[31:2]] = mem_d;
            ram_gen++;
        end
    end

    // CPU side: grant follows hold by one cycle, with forced or random stalls
    int stall_req = 0;
    bit rand_stall = 0;
    initial begin
        logic h;
        h = 1'b0;
        holdACK = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req > 0) begin
                holdACK = 1'b0;
                stall_req--;
            end else if (rand_stall && ($urandom_range(0, 3) == 0)) begin
                holdACK = 1'b0;
            end else begin
                holdACK = h;
            end
            h = hold;
        end
    end

    logic [63:0] exp_wr[$];
    int          exp_done[$];
    int          wr_seen = 0;
    int          done_seen = 0;
    int          wr_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_cnt = 0;
            end else begin
                if (mem_we) begin
                    logic [63:0] e;
                    wr_seen++;
                    wr_cnt++;
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", {32'd0, mem_a}, {32'd0, e[63:32]});
                        chk("wr_data", {32'd0, mem_d}, {32'd0, e[31:0]});
                    end
                end
                if (done) begin
                    done_seen++;
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        chk("words_written", 64'(wr_cnt), 64'(exp_done.pop_front()));
                    end
                    chk("hold_at_done", {63'd0, hold}, 64'd0);
                    wr_cnt = 0;
                end
            end
        end
    end

    // model: word-by-word copy of n words, pushing each expected write
    task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da, w;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            w = mdl_rd(sa[31:2]);
            exp_wr.push_back({da, w});
            mdl[da[31:2]] = w;
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic verify_region(input logic [31:0] d, input int n);
        logic [31:0] da;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            chk("mem_content", {32'd0, ram_rd(da[31:2])}, {32'd0, mdl_rd(da[31:2])});
            da = da + 32'd4;
        end
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk);
        #1;
        src = s; dst = d; len = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_seen == d0 && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (done_seen == d0) chk("done_timeout", 1, 0);
        @(posedge clk);
    endtask

    task automatic wait_writes(input int target);
        int t;
        t = 0;
        while (wr_seen < target && t < 1000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (wr_seen < target) chk("write_timeout", 1, 0);
    endtask

    initial begin
        int d0, w0, cyc;
        logic [31:0] s, d;
        int n;

        #2;
        chk("rst_hold", {63'd0, hold}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_mem_we", {63'd0, mem_we}, 0);
        chk("rst_mem_a", {32'd0, mem_a}, 0);
        chk("rst_mem_d", {32'd0, mem_d}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic copy with cycle timing
        d0 = done_seen;
        expect_copy(32'h100, 32'h200, 4);
        exp_done.push_back(4);
        @(posedge clk);
        #1;
        src = 32'h100; dst = 32'h200; len = 16'd4; start = 1'b1;
        @(negedge clk);
        chk("idle_before_start", {63'd0, busy}, 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("c1_hold", {63'd0, hold}, 1);
        chk("c1_busy", {63'd0, busy}, 1);
        @(negedge clk);
        @(negedge clk);
        chk("c3_rd_addr", {32'd0, mem_a}, 64'h100);
        chk("c3_rd_we", {63'd0, mem_we}, 0);
        cyc = 3;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", 64'(cyc), 64'(2 * 4 + 5));
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 0);
        chk("hold_after", {63'd0, hold}, 0);
        verify_region(32'h200, 4);

        // zero length
        d0 = done_seen;
        exp_done.push_back(0);
        @(posedge clk);
        #1;
        src = 32'h700; dst = 32'h780; len = 16'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("zero_done", {63'd0, done}, 1);
        chk("zero_hold", {63'd0, hold}, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_done_low", {63'd0, done}, 0);
            chk("zero_hold_low", {63'd0, hold}, 0);
        end

        // grant stall during WR of word 2, plus an ignored start while busy
        d0 = done_seen;
        w0 = wr_seen;
        expect_copy(32'h1000, 32'h2000, 4);
        exp_done.push_back(4);
        kick(32'h1000, 32'h2000, 16'd4);
        wait_writes(w0 + 1);
        @(negedge clk);
        stall_req = 5;
        @(posedge clk);
        #1;
        src = 32'h0; dst = 32'h40; len = 16'd7; start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_we", {63'd0, mem_we}, 0);
            chk("stall_addr", {32'd0, mem_a}, 64'h2004);
            start = 1'b0;
        end
        wait_done(d0);
        verify_region(32'h2000, 4);
        verify_region(32'h40, 7);

        // abort during RD of word 3
        d0 = done_seen;
        w0 = wr_seen;
        expect_copy(32'h400, 32'h800, 3);
        exp_done.push_back(3);
        kick(32'h400, 32'h800, 16'd10);
        wait_writes(w0 + 2);
        @(posedge clk);
        #1;
        chk("abort_in_rd", {32'd0, mem_a}, 64'h408);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(d0);
        verify_region(32'h800, 10);

        // source pointer wrap
        d0 = done_seen;
        expect_copy(32'hFFFF_FFF8, 32'h300, 3);
        exp_done.push_back(3);
        kick(32'hFFFF_FFFB, 32'h302, 16'd3);
        wait_done(d0);
        verify_region(32'h300, 3);

        // reset in WR of word 2
        w0 = wr_seen;
        expect_copy(32'h500, 32'h900, 1);
        kick(32'h500, 32'h900, 16'd5);
        wait_writes(w0 + 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_we", {63'd0, mem_we}, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", {63'd0, mem_we}, 0);
        chk("rst_mid_hold", {63'd0, hold}, 0);
        chk("rst_mid_busy", {63'd0, busy}, 0);
        chk("rst_mid_mem_a", {32'd0, mem_a}, 0);
        chk("rst_pending", 64'(exp_wr.size()), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        verify_region(32'h900, 5);

        // randomized copies with random grant stalls
        rand_stall = 1;
        for (int k = 0; k < 8; k++) begin
            s = 32'h1_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            d = 32'h2_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            n = $urandom_range(1, 8);
            d0 = done_seen;
            expect_copy(s, d, n);
            exp_done.push_back(n);
            kick(s, d, 16'(n));
            wait_done(d0);
            verify_region(d, n);
        end
        rand_stall = 0;

`ifdef HOLD_DMA_IRQ_EN
        d0 = done_seen;
        expect_copy(32'h3000, 32'h3100, 1);
        exp_done.push_back(1);
        kick(32'h3000, 32'h3100, 16'd1);
        while (!done && done_seen == d0) @(negedge clk);
        chk("irq_with_done", {63'd0, irq}, 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_set_wins", {63'd0, irq}, 1);
        @(negedge clk);
        chk("irq_held", {63'd0, irq}, 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_cleared", {63'd0, irq}, 0);
`endif

        repeat (3) @(negedge clk);
        chk("left_writes", 64'(exp_wr.size()), 0);
        chk("left_dones", 64'(exp_done.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
